// File: rtl/apb3_gpio_arbiter.sv
// Round-robin APB3 master sharing one GPIO slave port among N_REQ requesters.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | no transfer on the bus; arbitrate and accept one command
// ST_SETUP  | PSEL=1, PENABLE=0 with the latched command
// ST_ACCESS | PSEL=1, PENABLE=1; wait for PREADY (or timeout)
module apb3_gpio_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     io_apb_PCLK,
  input  logic                     io_apb_PRESETn,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        io_apb_PADDR,
  output logic                     io_apb_PSEL,
  output logic                     io_apb_PENABLE,
  output logic                     io_apb_PWRITE,
  output logic [DATA_W-1:0]        io_apb_PWDATA,
  input  logic                     io_apb_PREADY,
  input  logic [DATA_W-1:0]        io_apb_PRDATA
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand;
  int                  sum;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // Walk from lowest to highest priority so the last hit wins; offset 1 from
  // last_grant is highest priority, last_grant itself is lowest.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sum         = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      sum = int'(last_grant_q) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      cand = IDX_W'(sum);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    req_ready    = '0;
`ifdef APB_ARB_TIMEOUT_EN
    timer_d      = timer_q;
    rsp_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          paddr_d      = req_addr[grant_idx*ADDR_W +: ADDR_W];
          pwrite_d     = req_write[grant_idx];
          pwdata_d     = req_wdata[grant_idx*DATA_W +: DATA_W];
          psel_d       = 1'b1;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        timer_d   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
      end
      ST_ACCESS: begin
        if (io_apb_PREADY) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : io_apb_PRDATA;
          state_d              = ST_IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (timer_q == '0) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          state_d              = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge io_apb_PCLK) begin
    if (!io_apb_PRESETn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      owner_q      <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      timer_q      <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      timer_q      <= timer_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign io_apb_PADDR   = paddr_q;
  assign io_apb_PWRITE  = pwrite_q;
  assign io_apb_PWDATA  = pwdata_q;
  assign io_apb_PSEL    = psel_q;
  assign io_apb_PENABLE = penable_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
  assign rsp_err        = rsp_err_q;
`else
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_apb3_gpio_arbiter.sv
// Directed bench for apb3_gpio_arbiter (N_REQ=2); timeout scenario follows APB_ARB_TIMEOUT_EN.
module tb_apb3_gpio_arbiter;
  localparam int N = 2, AW = 3, DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req_valid = '0, req_write = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, pwdata, prdata = '0;
  logic          rsp_err, psel, penable, pwrite, pready = 1'b1;
  logic [AW-1:0] paddr;

  int vectors = 0;
  int errors  = 0;

  apb3_gpio_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .io_apb_PCLK(clk), .io_apb_PRESETn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_apb_PADDR(paddr), .io_apb_PSEL(psel), .io_apb_PENABLE(penable),
    .io_apb_PWRITE(pwrite), .io_apb_PWDATA(pwdata),
    .io_apb_PREADY(pready), .io_apb_PRDATA(prdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '0;
    tick(); tick(); #1;
    vectors++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {psel, penable, pwrite}); end
    vectors++; if ({paddr, pwdata} !== '0) begin errors++; $display("FAIL reset_addr_data got=%h exp=0", {paddr, pwdata}); end
    vectors++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin errors++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_rdata}); end
    vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write_single();
    req_valid = 2'b01; req_write = 2'b01; req_addr = '0; req_wdata = '0;
    req_wdata[31:0] = 32'h0000_3333; pready = 1'b1; prdata = 32'hDEAD_BEEF;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_accept got=%b exp=01", req_ready); end
    tick(); req_valid = '0; #1;
    vectors++; if ({req_ready, psel, penable} !== 4'b0010) begin errors++; $display("FAIL wr_setup got=%b exp=0010", {req_ready, psel, penable}); end
    tick(); #1;
    vectors++; if ({psel, penable, pwrite} !== 3'b111) begin errors++; $display("FAIL wr_access_ctrl got=%b exp=111", {psel, penable, pwrite}); end
    vectors++; if (paddr !== 3'd0 || pwdata !== 32'h0000_3333) begin errors++; $display("FAIL wr_access_cmd got=%h/%h exp=0/00003333", paddr, pwdata); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp got=%b/%h/%b exp=01/0/0", rsp_valid, rsp_rdata, rsp_err); end
    vectors++; if (psel !== 1'b0) begin errors++; $display("FAIL wr_idle_psel got=%b exp=0", psel); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_once got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_read_wait();
    req_valid = 2'b10; req_write = 2'b00; req_addr = '0; req_addr[5:3] = 3'd2;
    prdata = 32'h0000_A5A5; pready = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rd_accept got=%b exp=10", req_ready); end
    tick(); req_valid = '0;
    tick(); #1;
    vectors++; if ({psel, penable, pwrite, paddr} !== 6'b110_010) begin errors++; $display("FAIL rd_access1 got=%b exp=110010", {psel, penable, pwrite, paddr}); end
    tick(); #1;
    vectors++; if ({psel, penable, rsp_valid} !== 4'b1100) begin errors++; $display("FAIL rd_access2 got=%b exp=1100", {psel, penable, rsp_valid}); end
    tick(); pready = 1'b1; #1;
    vectors++; if ({psel, penable, rsp_valid} !== 4'b1100) begin errors++; $display("FAIL rd_access3 got=%b exp=1100", {psel, penable, rsp_valid}); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h0000_A5A5) begin errors++; $display("FAIL rd_rsp got=%b/%h exp=10/0000a5a5", rsp_valid, rsp_rdata); end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 2'b01; req_write = 2'b00; req_addr = '0; req_addr[2:0] = 3'd1;
    prdata = 32'hFFFF_FFFF; pready = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL to_accept got=%b exp=01", req_ready); end
    tick(); req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      vectors++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL to_access%0d got=%b exp=11", k, {psel, penable}); end
    end
    tick(); #1;
    vectors++; if ({psel, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rsp got=%b/%h exp=0011/0", {psel, rsp_valid, rsp_err}, rsp_rdata); end
    req_valid = 2'b01; prdata = 32'h1234_5678;
    tick(); req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    tick(); pready = 1'b1; #1;
    vectors++; if ({psel, penable, rsp_valid} !== 4'b1100) begin errors++; $display("FAIL to_last_cycle got=%b exp=1100", {psel, penable, rsp_valid}); end
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL to_edge_ok got=%b/%b/%h exp=01/0/12345678", rsp_valid, rsp_err, rsp_rdata); end
  endtask
`else
  task automatic test_no_timeout();
    int ok;
    ok = 0;
    req_valid = 2'b01; req_write = 2'b00; req_addr = '0; prdata = 32'h0000_BEEF; pready = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL nto_accept got=%b exp=01", req_ready); end
    tick(); req_valid = '0;
    for (int k = 0; k < 100; k++) begin
      tick(); #1;
      if (psel && penable && rsp_valid == 2'b00) ok++;
    end
    vectors++; if (ok !== 100) begin errors++; $display("FAIL nto_hold got=%0d exp=100", ok); end
    tick(); pready = 1'b1;
    tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL nto_rsp got=%b/%b/%h exp=01/0/0000beef", rsp_valid, rsp_err, rsp_rdata); end
  endtask
`endif

  task automatic test_fairness();
    logic [1:0] exp_rdy, exp_rsp;
    rstn = 1'b0; req_valid = '0; pready = 1'b1;
    tick(); rstn = 1'b1;
    tick();
    req_write = 2'b00; prdata = 32'h0000_0001;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      req_valid = (cyc < 12) ? 2'b11 : 2'b00;
      #1;
      exp_rdy = 2'b00;
      exp_rsp = 2'b00;
      if (cyc % 3 == 0 && cyc < 12) exp_rdy = ((cyc / 3) % 2 == 1) ? 2'b10 : 2'b01;
      if (cyc >= 3 && cyc % 3 == 0) exp_rsp = (((cyc / 3) - 1) % 2 == 1) ? 2'b10 : 2'b01;
      vectors++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
      vectors++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_rsp c%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_write = 2'b01; req_addr = '0; req_addr[2:0] = 3'd5;
    req_wdata = '0; req_wdata[31:0] = 32'h0000_1234; pready = 1'b0;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_accept got=%b exp=01", req_ready); end
    tick(); req_valid = '0;
    tick(); #1;
    vectors++; if ({psel, penable, paddr} !== 5'b11_101) begin errors++; $display("FAIL rst_access got=%b exp=11101", {psel, penable, paddr}); end
    rstn = 1'b0;
    tick(); #1;
    vectors++; if ({psel, penable, rsp_valid, paddr} !== 7'b0) begin errors++; $display("FAIL rst_abort got=%b exp=0", {psel, penable, rsp_valid, paddr}); end
    rstn = 1'b1; pready = 1'b1;
    tick(); #1;
    vectors++; if ({psel, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rst_no_rsp got=%b exp=000", {psel, rsp_valid}); end
    req_valid = 2'b10; req_write = 2'b00; req_addr[5:3] = 3'd3; prdata = 32'h0000_0F0F;
    #1;
    vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rst_req1 got=%b exp=10", req_ready); end
    tick(); req_valid = '0;
    tick(); tick(); #1;
    vectors++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h0000_0F0F) begin errors++; $display("FAIL rst_req1_rsp got=%b/%h exp=10/00000f0f", rsp_valid, rsp_rdata); end
    req_valid = 2'b11; prdata = 32'h0000_00C3;
    #1;
    vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_conflict got=%b exp=01", req_ready); end
    tick(); req_valid = '0;
    tick(); tick(); #1;
    vectors++; if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h0000_00C3) begin errors++; $display("FAIL rst_conflict_rsp got=%b/%h exp=01/000000c3", rsp_valid, rsp_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy, exp_rsp;
    req_valid = 2'b01; req_write = 2'b01; pready = 1'b1;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      #1;
      exp_rdy = (cyc % 3 == 0) ? 2'b01 : 2'b00;
      exp_rsp = (cyc > 0 && cyc % 3 == 0) ? 2'b01 : 2'b00;
      vectors++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
      vectors++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL b2b_rsp c%0d got=%b exp=%b", cyc, rsp_valid, exp_rsp); end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_single();
    test_read_wait();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_fairness();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
